// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the scoreboarded register file: sizes and the
// outstanding-write counter type used by the top and the counter cells.
package reg_file_sb_pkg;

  localparam int NREG   = 32;
  localparam int SB_MAX = 3;
  localparam int CNT_W  = $clog2(SB_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file. The pipeline side drives
// through the master modport; the register file sits on the slave modport.
interface reg_file_sb_if #(
  parameter int NREG = reg_file_sb_pkg::NREG
);

  logic                      wbEn;
  logic [4:0]                wd;
  logic [63:0]               wbData;
  logic [4:0]                rs1;
  logic [4:0]                rs2;
  logic [63:0]               rdata1;
  logic [63:0]               rdata2;
  logic                      busy1;
  logic                      busy2;
  logic                      claimEn;
  logic [4:0]                claimRd;
  logic                      claimReady;
  logic                      flush;
  logic [NREG-1:0][63:0]     regsOut;

  modport master (
    output wbEn, wd, wbData, rs1, rs2, claimEn, claimRd, flush,
    input  rdata1, rdata2, busy1, busy2, claimReady, regsOut
  );

  modport slave (
    input  wbEn, wd, wbData, rs1, rs2, claimEn, claimRd, flush,
    output rdata1, rdata2, busy1, busy2, claimReady, regsOut
  );

endinterface

// File: rtl/reg_file_sb_counter.sv
// Saturating outstanding-write counter for one architectural register.
// inc and dec together cancel; clr wins over both.
module sb_counter
  import reg_file_sb_pkg::*;
#(
  parameter int MAX = reg_file_sb_pkg::SB_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output cnt_t cnt,
  output logic sat
);

  assign sat = (cnt == cnt_t'(MAX));

  // Count claims up and writebacks down, never past MAX or below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && !sat) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// 64-bit architectural register file with same-cycle write bypass and a
// per-register scoreboard of outstanding writes. x0 reads as zero and has
// no counter. SB_MAX must fit in the package counter type.
module reg_file_sb #(
  parameter int NREG   = reg_file_sb_pkg::NREG,
  parameter int SB_MAX = reg_file_sb_pkg::SB_MAX
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);

  import reg_file_sb_pkg::*;

  logic [63:0] regs [NREG];
  cnt_t        cnt  [NREG];
  logic        sat  [NREG];
  logic        wbHit;

  // A writeback to x0 is dropped everywhere: no store, no bypass, no count.
  assign wbHit = bus.wbEn && (bus.wd != '0);

  // Architectural state; writes land on the edge, x0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (wbHit) begin
      regs[bus.wd] <= bus.wbData;
    end
  end

  // Reads bypass the writeback in flight; reset forces zero.
  assign bus.rdata1 = (rst || (bus.rs1 == '0)) ? '0 :
                      (wbHit && (bus.wd == bus.rs1)) ? bus.wbData : regs[bus.rs1];
  assign bus.rdata2 = (rst || (bus.rs2 == '0)) ? '0 :
                      (wbHit && (bus.wd == bus.rs2)) ? bus.wbData : regs[bus.rs2];

  // An operand whose last outstanding write is retiring this cycle is not busy.
  assign bus.busy1 = !rst && (bus.rs1 != '0) && (cnt[bus.rs1] != '0) &&
                     !((cnt[bus.rs1] == cnt_t'(1)) && wbHit && (bus.wd == bus.rs1));
  assign bus.busy2 = !rst && (bus.rs2 != '0) && (cnt[bus.rs2] != '0) &&
                     !((cnt[bus.rs2] == cnt_t'(1)) && wbHit && (bus.wd == bus.rs2));

  // A full counter still accepts a claim when a writeback frees a slot now.
  assign bus.claimReady = rst || (bus.claimRd == '0) || !sat[bus.claimRd] ||
                          (wbHit && (bus.wd == bus.claimRd));

  assign cnt[0]         = '0;
  assign sat[0]         = 1'b0;
  assign bus.regsOut[0] = regs[0];

  for (genvar r = 1; r < NREG; r++) begin : gCnt
    logic inc;
    logic dec;

    assign inc = bus.claimEn && bus.claimReady && (bus.claimRd == 5'(r)) && !bus.flush;
    assign dec = wbHit && (bus.wd == 5'(r)) && !bus.flush;

    sb_counter #(
      .MAX (SB_MAX)
    ) uCnt (
      .clk (clk),
      .rst (rst),
      .inc (inc),
      .dec (dec),
      .clr (bus.flush),
      .cnt (cnt[r]),
      .sat (sat[r])
    );

    assign bus.regsOut[r] = regs[r];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, x0, scoreboard saturation,
// retire-in-same-cycle, flush and asynchronous reset.
module tb_reg_file_sb;

  logic clk;
  logic rst;
  int   nVec;
  int   nErr;

  reg_file_sb_if #(.NREG(32)) bus ();

  reg_file_sb #(
    .NREG   (32),
    .SB_MAX (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wbEn    = 1'b0;
    bus.wd      = '0;
    bus.wbData  = '0;
    bus.rs1     = '0;
    bus.rs2     = '0;
    bus.claimEn = 1'b0;
    bus.claimRd = '0;
    bus.flush   = 1'b0;
  endtask

  // Advance past one rising edge; inputs change and checks happen mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    idle();
    rst = 1'b1;

    // Reset: inputs ignored, outputs at rest values
    #2;
    bus.wbEn = 1'b1; bus.wd = 5'd5; bus.wbData = 64'hFFFF; bus.rs1 = 5'd5;
    bus.claimRd = 5'd5;
    #1;
    chk("rst_rdata1", bus.rdata1, 64'h0);
    chk("rst_busy1", {63'h0, bus.busy1}, 64'h0);
    chk("rst_claimReady", {63'h0, bus.claimReady}, 64'h1);
    chk("rst_regsOut5", bus.regsOut[5], 64'h0);
    step();
    chk("rst_hold_regsOut5", bus.regsOut[5], 64'h0);
    idle();
    rst = 1'b0;
    step();

    // Write bypass and one-cycle regsOut latency
    bus.wbEn = 1'b1; bus.wd = 5'd5; bus.wbData = 64'hDEAD; bus.rs1 = 5'd5;
    #1;
    chk("bypass_rdata1", bus.rdata1, 64'hDEAD);
    chk("pre_regsOut5", bus.regsOut[5], 64'h0);
    step();
    idle();
    bus.rs1 = 5'd5;
    #1;
    chk("post_regsOut5", bus.regsOut[5], 64'hDEAD);
    chk("stored_rdata1", bus.rdata1, 64'hDEAD);

    // Writes to x0 are ignored
    bus.wbEn = 1'b1; bus.wd = 5'd0; bus.wbData = 64'h1234; bus.rs1 = 5'd0;
    #1;
    chk("x0_rdata1", bus.rdata1, 64'h0);
    step();
    idle();
    #1;
    chk("x0_regsOut0", bus.regsOut[0], 64'h0);

    // Three claims on x7 saturate the counter
    bus.claimEn = 1'b1; bus.claimRd = 5'd7; bus.rs1 = 5'd7;
    step();
    step();
    #1;
    chk("x7_cnt2_ready", {63'h0, bus.claimReady}, 64'h1);
    step();
    #1;
    chk("x7_full_ready", {63'h0, bus.claimReady}, 64'h0);
    chk("x7_busy1", {63'h0, bus.busy1}, 64'h1);
    step();
    bus.claimEn = 1'b0;
    bus.wbEn = 1'b1; bus.wd = 5'd7; bus.wbData = 64'h77;
    #1;
    chk("x7_wb_ready", {63'h0, bus.claimReady}, 64'h1);
    chk("x7_wb_busy1", {63'h0, bus.busy1}, 64'h1);
    step();
    idle();
    bus.claimRd = 5'd7; bus.rs1 = 5'd7;
    #1;
    chk("x7_cnt2_after_ready", {63'h0, bus.claimReady}, 64'h1);
    chk("x7_cnt2_after_busy1", {63'h0, bus.busy1}, 64'h1);
    chk("x7_regsOut", bus.regsOut[7], 64'h77);

    // x9 with one outstanding write: retiring write unblocks and bypasses
    idle();
    bus.claimEn = 1'b1; bus.claimRd = 5'd9;
    step();
    idle();
    bus.rs2 = 5'd9;
    #1;
    chk("x9_busy2_cnt1", {63'h0, bus.busy2}, 64'h1);
    bus.wbEn = 1'b1; bus.wd = 5'd9; bus.wbData = 64'h99;
    bus.claimEn = 1'b1; bus.claimRd = 5'd9;
    #1;
    chk("x9_retire_busy2", {63'h0, bus.busy2}, 64'h0);
    chk("x9_retire_rdata2", bus.rdata2, 64'h99);
    step();
    idle();
    bus.rs2 = 5'd9;
    #1;
    chk("x9_claim_wb_cnt_kept", {63'h0, bus.busy2}, 64'h1);
    bus.wbEn = 1'b1; bus.wd = 5'd9; bus.wbData = 64'h9A;
    step();
    idle();
    bus.rs2 = 5'd9;
    #1;
    chk("x9_drained_busy2", {63'h0, bus.busy2}, 64'h0);
    chk("x9_rdata2", bus.rdata2, 64'h9A);

    // Flush discards every claim but keeps the writeback data
    idle();
    bus.claimEn = 1'b1; bus.claimRd = 5'd3;
    step();
    step();
    bus.claimRd = 5'd4;
    step();
    idle();
    bus.rs1 = 5'd3; bus.rs2 = 5'd4;
    #1;
    chk("pre_flush_busy1", {63'h0, bus.busy1}, 64'h1);
    chk("pre_flush_busy2", {63'h0, bus.busy2}, 64'h1);
    bus.flush = 1'b1; bus.claimEn = 1'b1; bus.claimRd = 5'd3;
    bus.wbEn = 1'b1; bus.wd = 5'd4; bus.wbData = 64'h44;
    step();
    idle();
    bus.rs1 = 5'd3; bus.rs2 = 5'd4;
    #1;
    chk("flush_busy1_x3", {63'h0, bus.busy1}, 64'h0);
    chk("flush_busy2_x4", {63'h0, bus.busy2}, 64'h0);
    chk("flush_wb_regsOut4", bus.regsOut[4], 64'h44);
    bus.rs1 = 5'd7;
    #1;
    chk("flush_busy1_x7", {63'h0, bus.busy1}, 64'h0);

    // Asynchronous reset between edges with x8 busy
    idle();
    bus.claimEn = 1'b1; bus.claimRd = 5'd8;
    step();
    step();
    step();
    idle();
    bus.wbEn = 1'b1; bus.wd = 5'd8; bus.wbData = 64'h55;
    step();
    idle();
    bus.rs1 = 5'd8; bus.claimRd = 5'd8;
    #1;
    chk("x8_busy1", {63'h0, bus.busy1}, 64'h1);
    chk("x8_regsOut", bus.regsOut[8], 64'h55);
    rst = 1'b1;
    #1;
    chk("arst_busy1", {63'h0, bus.busy1}, 64'h0);
    chk("arst_regsOut8", bus.regsOut[8], 64'h0);
    chk("arst_regsOut5", bus.regsOut[5], 64'h0);
    chk("arst_rdata1", bus.rdata1, 64'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_busy1", {63'h0, bus.busy1}, 64'h0);
    chk("post_rst_ready", {63'h0, bus.claimReady}, 64'h1);
    bus.wbEn = 1'b1; bus.wd = 5'd8; bus.wbData = 64'hAB;
    step();
    idle();
    #1;
    chk("post_rst_regsOut8", bus.regsOut[8], 64'hAB);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter NREG, default 32, architectural register count (x0..x31).
REQ-002 SHALL have parameter SB_MAX, default 3, maximum outstanding writes tracked per register.
REQ-003 SHALL have port clk  input  1  clock, rising edge active.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wbEn  input  1  writeback write enable from writeback stage.
REQ-006 SHALL have port wd  input  5  writeback destination register index.
REQ-007 SHALL have port wbData  input  64  writeback data.
REQ-008 SHALL have port rs1, rs2  input  5 each  decode read indices.
REQ-009 SHALL have port rdata1, rdata2  output  64 each  read data, combinational.
REQ-010 SHALL have port busy1, busy2  output  1 each  operand still has an outstanding write.
REQ-011 SHALL have port claimEn  input  1  decode issues an instruction that will write claimRd.
REQ-012 SHALL have port claimRd  input  5  register being claimed.
REQ-013 SHALL have port claimReady  output  1  claim of claimRd can be accepted this cycle.
REQ-014 SHALL have port flush  input  1  pipeline flush; discard all outstanding claims.
REQ-015 SHALL have port regsOut  output  NREG x 64  architectural state snapshot for commit checking.

Function
REQ-016 SHALL write wbData into register wd on the rising clk edge when wbEn=1 and wd!=0.
REQ-017 SHALL hold x0 at 0 permanently; writes to x0 are ignored.
REQ-018 SHALL return rdataN = wbData when wbEn=1, wd=rsN, wd!=0 (same-cycle write bypass); otherwise stored value; rsN=0 returns 0.
REQ-019 SHALL keep a per-register outstanding counter cnt[r], range 0..SB_MAX.
REQ-020 SHALL increment cnt[claimRd] on edge when claimEn=1, claimReady=1, claimRd!=0 and flush=0.
REQ-021 SHALL decrement cnt[wd] on edge when wbEn=1, wd!=0, cnt[wd]>0 and flush=0; cnt never underflows.
REQ-022 SHALL leave cnt unchanged when claim and writeback target the same register in the same cycle.
REQ-023 SHALL drive claimReady = 0 only when claimRd!=0 and cnt[claimRd]=SB_MAX and no same-cycle writeback to claimRd; claimEn with claimReady=0 has no effect.
REQ-024 SHALL drive busyN = 1 when rsN!=0 and cnt[rsN]>0, except 0 when cnt[rsN]=1 and same-cycle writeback to rsN.
REQ-025 SHALL on flush=1 clear all cnt to 0 on that edge, overriding claims and decrements; the writeback data write still occurs.
REQ-026 SHALL drive regsOut from stored registers only (no bypass); latency one cycle after write.

Reset
REQ-027 SHALL on rst clear all registers to 0 and all cnt to 0 immediately, regardless of clk.
REQ-028 SHALL, with rst asserted, present rdata=0, busy=0, claimReady=1, regsOut all 0; inputs ignored.
REQ-029 SHALL resume normal operation on first clk edge after rst deasserts, with reset mid-operation discarding all claims.

Structure
REQ-030 SHALL place NREG, SB_MAX and counter width typedef in the shared common package.
REQ-031 SHALL implement per-register counter as sub-module sb_counter (inc, dec, clr, saturation flag), instantiated NREG-1 times.

Verification
REQ-032 SHALL cover: wbEn=1 wd=5 wbData=0xDEAD, rs1=5 same cycle -> rdata1=0xDEAD; next cycle regsOut[5]=0xDEAD.
REQ-033 SHALL cover: wbEn=1 wd=0 wbData=0x1234 -> rdata for rs1=0 stays 0, regsOut[0]=0.
REQ-034 SHALL cover: claim x7 three times -> cnt=3, claimReady=0 for claimRd=7, busy1=1 for rs1=7; one writeback to x7 -> cnt=2, claimReady=1.
REQ-035 SHALL cover: cnt[9]=1, same cycle wbEn wd=9 and rs2=9 -> busy2=0, rdata2=wbData; simultaneous claim and writeback on x9 -> cnt unchanged.
REQ-036 SHALL cover: cnt[3]=2, cnt[4]=1, flush=1 with claimEn on x3 -> all cnt=0 next cycle, busy deasserted.
REQ-037 SHALL cover: rst pulse asynchronously between edges with cnt[8]=2, x8=0x55 -> immediately busy=0, regsOut[8]=0.
